// File: rtl/queue_ctrl_2x81.sv
// Two-entry, 81-bit ready/valid FIFO controller driving an external 2x81 register-file macro.
// Optional same-cycle bypass when empty: define QUEUE_CTRL_2X81_FLOW_EN.
module queue_ctrl_2x81 (
  input  logic        clock,
  input  logic        reset,
  output logic        io_enq_ready,
  input  logic        io_enq_valid,
  input  logic [80:0] io_enq_bits,
  input  logic        io_deq_ready,
  output logic        io_deq_valid,
  output logic [80:0] io_deq_bits,
  output logic [1:0]  io_count,
  output logic        ram_R0_addr,
  output logic        ram_R0_en,
  input  logic [80:0] ram_R0_data,
  output logic        ram_W0_addr,
  output logic        ram_W0_en,
  output logic [80:0] ram_W0_data
);

  localparam int DATA_W = 81;

  logic              enq_ptr;
  logic              deq_ptr;
  logic              maybe_full;
  logic              ptr_match;
  logic              empty;
  logic              full;
  logic              do_enq;
  logic              do_deq;
  logic [DATA_W-1:0] head_bits;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  assign io_enq_ready = ~full;
  assign head_bits    = ram_R0_data;

  always_comb begin
    io_deq_valid = ~empty;
    io_deq_bits  = head_bits;
    do_enq       = io_enq_ready & io_enq_valid;
    do_deq       = io_deq_ready & ~empty;
`ifdef QUEUE_CTRL_2X81_FLOW_EN
    // Empty queue: present the incoming entry directly; if it is taken now, never store it.
    if (empty) begin
      io_deq_valid = io_enq_valid;
      io_deq_bits  = io_enq_bits;
      if (io_deq_ready) begin
        do_enq = 1'b0;
      end
    end
`endif
  end

  assign io_count = full ? 2'd2 : {1'b0, enq_ptr ^ deq_ptr};

  assign ram_W0_en   = do_enq & ~reset;
  assign ram_W0_addr = enq_ptr;
  assign ram_W0_data = io_enq_bits;

  // Combinational read port kept enabled so the macro output is never X.
  assign ram_R0_en   = 1'b1;
  assign ram_R0_addr = deq_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= 1'b0;
      deq_ptr    <= 1'b0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr <= ~enq_ptr;
      end
      if (do_deq) begin
        deq_ptr <= ~deq_ptr;
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

endmodule
